regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Round-robin arbiter sharing the single register-file write port between two requesters: the pipeline writeback stage (requester 0) and the multiply/divide unit (requester 1). It accepts one valid/ready write request per cycle and drives a registered write-enable, write-address and write-data toward the 32 × 32-bit register file. Writes to register 0 are accepted and discarded. A saturating counter records contention cycles for performance debug.

## Interface
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, width of register address
- CNT_WIDTH, 8, width of contention counter
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 (writeback) has a write pending
- req0_addr  input  ADDR_WIDTH  requester 0 destination register
- req0_data  input  DATA_WIDTH  requester 0 write data
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid  input  1  requester 1 (multdiv) has a write pending
- req1_addr  input  ADDR_WIDTH  requester 1 destination register
- req1_data  input  DATA_WIDTH  requester 1 write data
- req1_ready  output  1  requester 1 accepted this cycle
- rf_we  output  1  register-file write enable, registered
- rf_waddr  output  ADDR_WIDTH  register-file write address, registered
- rf_wdata  output  DATA_WIDTH  register-file write data, registered
- last_grant  output  1  requester granted most recently, registered
- contention_cnt  output  CNT_WIDTH  saturating count of cycles with both requests valid

## Operation
- One clock; reset is asynchronous and active-low.
- Transfer on requester i occurs in a cycle where reqi_valid=1 and reqi_ready=1.
- reqi_ready is combinational from valids and priority state; at most one ready is high per cycle.
- Requester must hold valid, addr and data stable until its transfer. Deasserting valid before transfer is illegal; behaviour is undefined.
- Priority state machine, two states:
  - PRI0: requester 0 wins a tie.
  - PRI1: requester 1 wins a tie.
- Grant rules:
  - Only one valid: that requester is granted, whatever the state.
  - Both valid: the state selects the winner.
  - Neither valid: no grant.
- Transitions: after any grant to requester 0, next state is PRI1. After any grant to requester 1, next state is PRI0. With no grant, state holds.
- Output register, updated every cycle:
  - Grant with addr≠0: rf_we=1, rf_waddr=addr, rf_wdata=data of the winner.
  - Grant with addr=0: rf_we=0. The transfer still completes, so ready is still 1.
  - No grant: rf_we=0; rf_waddr and rf_wdata hold their previous values.
- last_grant: updated to the winner index on every grant and held otherwise, including addr=0 grants.
- contention_cnt: increments by 1 in each cycle where req0_valid and req1_valid are both 1. It saturates at 2^CNT_WIDTH−1 and does not wrap. It clears only on reset.

## Timing
- Reset (async assert, any time): state=PRI0, rf_we=0, rf_waddr=0, rf_wdata=0, last_grant=0, contention_cnt=0. Both readys read 0 while reset_n=0.
- A mid-operation reset drops any request that has not yet been registered. The requester must re-present it after reset.
- Accept-to-write latency: 1 cycle. A grant in cycle N produces rf_we=1 in cycle N+1, so the register file captures the data on edge N+2.
- Throughput: one write per cycle sustained.
- Under continuous contention, grants strictly alternate 0,1,0,1… Neither requester waits more than 1 cycle once the other has been served.

## Test plan
- Reset then idle: rf_we=0, both readys=0, contention_cnt=0 for 10 cycles.
- Single requester: req0 valid with addr=5, data=0xDEADBEEF. Required: req0_ready=1 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, last_grant=0.
- Contention from reset, both valid for 4 cycles with distinct addr/data:
  - Grants are 0,1,0,1 and rf_waddr follows that order.
  - contention_cnt=4 at the end.
  - Each requester holds until its ready.
- Register 0: req1 valid with addr=0, data=0x12345678. Required: req1_ready=1; next cycle rf_we=0 and rf_wdata unchanged; last_grant=1; state becomes PRI0.
- Saturation: both valid continuously for 300 cycles with CNT_WIDTH=8. Required: contention_cnt stops at 255 and stays there.
- Reset mid-stream: assert reset_n=0 asynchronously between clock edges while rf_we=1. Required: rf_we, rf_waddr, rf_wdata and contention_cnt go to 0 immediately, without waiting for a clock edge; after release the first contended grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port (writeback vs. multdiv).
// Registered write outputs, a writes-to-r0 discard, and a saturating contention counter.
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  last_grant,
  output logic [CNT_WIDTH-1:0]  contention_cnt,
  output logic                  pri_state
);

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  pri_e                  state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  grant0, grant1;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Handshake: a transfer on requester i happens in any cycle with reqi_valid && reqi_ready.
  // Ready is combinational from both valids and the priority state, never both high, and
  // forced low while reset_n is asserted. Requesters hold valid/addr/data until transfer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      grant0 = req0_valid && (!req1_valid || (state_q == PRI0));
      grant1 = req1_valid && (!req0_valid || (state_q == PRI1));
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign win_addr   = grant1 ? req1_addr : req0_addr;
  assign win_data   = grant1 ? req1_data : req0_data;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    if (grant0) begin
      state_d = PRI1;
      last_d  = 1'b0;
    end else if (grant1) begin
      state_d = PRI0;
      last_d  = 1'b1;
    end

    // A write to r0 completes the handshake but leaves the register file untouched.
    if ((grant0 || grant1) && (win_addr != '0)) begin
      we_d    = 1'b1;
      waddr_d = win_addr;
      wdata_d = win_data;
    end

    if (req0_valid && req1_valid && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PRI0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we          = we_q;
  assign rf_waddr       = waddr_q;
  assign rf_wdata       = wdata_q;
  assign last_grant     = last_q;
  assign contention_cnt = cnt_q;
  assign pri_state      = state_q;

endmodule
